inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache sitting directly upstream of instruction fetch.
//  - Services fetch's one-line requests (ic_enable/iaddr) and returns a full 64-byte line on idata with an ic_done pulse.
//  - On a miss, refills the line from the memory bus as 8 x 64-bit beats.
// PARAMETERS
//  LINES   64  number of cache lines; power of 2, >= 2; IDX_W = $clog2(LINES)
//  ADDR_W  64  address width; tag = addr[ADDR_W-1:6+IDX_W], index = addr[6+IDX_W-1:6]
// PORTS
//  clk          in   1    clock; all logic on posedge
//  reset_n      in   1    asynchronous active-low reset
//  ic_enable    in   1    request strobe from fetch; sampled in IDLE only
//  iaddr        in   64   request address; bits [5:0] ignored
//  idata        out  512  line data; 64-bit word k (addr line+8k) at idata[k*64+:64], little-endian bytes
//  ic_done      out  1    one-cycle pulse: idata valid, held until next ic_done
//  flush        in   1    invalidate all lines (e.g. on set_rip / self-modifying code)
//  mem_reqcyc   out  1    memory read request valid
//  mem_req      out  64   line-aligned request address (addr & ~63)
//  mem_reqack   in   1    request accepted this cycle
//  mem_respcyc  in   1    response beat valid
//  mem_resp     in   64   response beat data; beats arrive in order, word 0 first
//  mem_respack  out  1    = mem_respcyc (always accept)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - all valid bits 0; state IDLE.
//   - ic_done=0, idata=0, mem_reqcyc=0, mem_req=0, beat count=0.
//   - Tag/data arrays are not reset.
//  FSM IDLE -> REQ -> RESP -> FILL -> IDLE.
//  IDLE:
//   - ic_enable=1 and hit (valid[idx] and tag match): idata<=data[idx], ic_done=1 next cycle; stay IDLE.
//     Hit latency is 1 cycle.
//   - ic_enable=1 and miss: latch line address, mem_reqcyc<=1, mem_req<=addr&~63; go to REQ.
//  REQ:
//   - Hold mem_reqcyc/mem_req stable until mem_reqack.
//   - On mem_reqack: mem_reqcyc<=0, beat count<=0; go to RESP.
//  RESP:
//   - Each mem_respcyc cycle writes mem_resp into line buffer word[cnt] and increments the 3-bit cnt.
//   - After beat 7: go to FILL.
//   - mem_respcyc=0 cycles are stalls.
//  FILL:
//   - Write buffer to data[idx], tag to tag[idx], valid[idx]<=1 (unless a flush occurred during the refill).
//   - idata<=buffer, ic_done=1 next cycle; go to IDLE.
//   - Miss latency is 3 cycles plus reqack wait plus beat arrival.
//  Boundaries:
//   - ic_enable outside IDLE is ignored; fetch keeps at most one request outstanding.
//   - ic_enable while ic_done=1 is legal: it starts a new lookup that same cycle.
//   - flush in IDLE clears all valid bits next cycle.
//   - flush coinciding with an IDLE ic_enable: the lookup misses.
//   - flush during REQ/RESP/FILL: valid bits clear; the refill completes and ic_done still pulses with the fetched data, but valid is not set.
//   - Refilling a valid index evicts the old line (conflict).
//   - Index wrap: address line (LINES*64)+A maps to the same index as A.
//   - reset_n low mid-refill: immediate return to IDLE with reset values; the cache ignores remaining beats until the next request.
// CONFIGURATION
//  ICACHE_STATS_EN:
//   - Defined: adds outputs hit_count[31:0] and miss_count[31:0].
//     Each increments once per accepted IDLE request classified hit/miss, wraps at 2^32, and resets to 0.
//     Flush does not clear them.
//   - Undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1 Reset:
//   - Hold reset_n=0 -> ic_done=0, mem_reqcyc=0, idata=0.
//   - Release, then ic_enable iaddr=0x1000 -> miss, mem_reqcyc=1, mem_req=0x1000.
//  2 Cold miss:
//   - reqack after 2 cycles; beats 0x11..0x88 with one stall.
//   - -> ic_done pulse 1 cycle after FILL; idata[0+:64]=0x11, idata[448+:64]=0x88.
//  3 Hit:
//   - Re-request iaddr=0x1023 -> ic_done next cycle, same idata, mem_reqcyc stays 0.
//  4 Conflict:
//   - Request 0x1000+64*LINES -> miss and refill; then 0x1000 -> miss again.
//  5 Flush:
//   - Flush after scenario 3, then 0x1000 -> miss.
//   - Flush during RESP -> ic_done still pulses; a following 0x1000 request misses.
//  6 Reset mid-RESP:
//   - reset_n=0 after beat 3 -> IDLE, mem_reqcyc=0, no ic_done.
//   - With ICACHE_STATS_EN: hit_count/miss_count match scenarios 2-4 (1 hit, 3 misses) before the reset.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache; 64-byte lines, 8-beat refill.
// Optional ICACHE_STATS_EN adds hit/miss counters.
module inst_cache #(
  parameter int LINES  = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_enable,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [511:0]      idata,
  output logic              ic_done,
  input  logic              flush,
  output logic              mem_reqcyc,
  output logic [ADDR_W-1:0] mem_req,
  input  logic              mem_reqack,
  input  logic              mem_respcyc,
  input  logic [63:0]       mem_resp,
  output logic              mem_respack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 6 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FILL
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [511:0]     data_mem [LINES];
  logic [511:0]     line_buf;
  logic [2:0]       cnt;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             flushed;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             fill_valid;
  logic             unused_bits;

  assign idx         = iaddr[6+IDX_W-1:6];
  assign tag         = iaddr[ADDR_W-1:6+IDX_W];
  assign unused_bits = ^iaddr[5:0];
  assign mem_respack = mem_respcyc;

  // A flush in the lookup cycle forces a miss.
  assign hit = valid[idx] && (tag_mem[idx] == tag) && !flush;

  assign fill_valid = !flushed && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ic_enable && !hit) state_nxt = REQ;
      REQ:  if (mem_reqack) state_nxt = RESP;
      RESP: if (mem_respcyc && cnt == 3'd7) state_nxt = FILL;
      FILL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= '0;
      ic_done    <= 1'b0;
      idata      <= '0;
      mem_reqcyc <= 1'b0;
      mem_req    <= '0;
      cnt        <= '0;
      req_idx    <= '0;
      req_tag    <= '0;
      flushed    <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      if (flush) valid <= '0;
      unique case (state)
        IDLE: begin
          if (ic_enable) begin
            if (hit) begin
              idata   <= data_mem[idx];
              ic_done <= 1'b1;
            end else begin
              req_idx    <= idx;
              req_tag    <= tag;
              mem_reqcyc <= 1'b1;
              mem_req    <= {iaddr[ADDR_W-1:6], 6'd0};
              flushed    <= 1'b0;
            end
          end
        end
        REQ: begin
          if (flush) flushed <= 1'b1;
          if (mem_reqack) begin
            mem_reqcyc <= 1'b0;
            cnt        <= '0;
          end
        end
        RESP: begin
          if (flush) flushed <= 1'b1;
          if (mem_respcyc) cnt <= cnt + 3'd1;
        end
        FILL: begin
          // Data fetched across a flush is delivered but not retained.
          if (fill_valid) valid[req_idx] <= 1'b1;
          idata   <= line_buf;
          ic_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && mem_respcyc)
      line_buf[{cnt, 6'd0} +: 64] <= mem_resp;
    if (state == FILL) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= line_buf;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && ic_enable) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: reset, cold miss, hit, conflict,
// flush cases and reset in the middle of a refill.
module tb_inst_cache;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ic_enable;
  logic [63:0]  iaddr;
  logic [511:0] idata;
  logic         ic_done;
  logic         flush;
  logic         mem_reqcyc;
  logic [63:0]  mem_req;
  logic         mem_reqack;
  logic         mem_respcyc;
  logic [63:0]  mem_resp;
  logic         mem_respack;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  inst_cache #(.LINES(64), .ADDR_W(64)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ic_enable(ic_enable),
    .iaddr(iaddr),
    .idata(idata),
    .ic_done(ic_done),
    .flush(flush),
    .mem_reqcyc(mem_reqcyc),
    .mem_req(mem_req),
    .mem_reqack(mem_reqack),
    .mem_respcyc(mem_respcyc),
    .mem_resp(mem_resp),
    .mem_respack(mem_respack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [63:0] a, input logic f);
    ic_enable = 1'b1;
    iaddr     = a;
    flush     = f;
    tick();
    ic_enable = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic refill(input logic [63:0] b0, input logic [63:0] step,
                        input int stall_at, input int flush_at);
    mem_reqack = 1'b1;
    tick();
    mem_reqack = 1'b0;
    check("reqcyc_drop", {63'd0, mem_reqcyc}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        mem_respcyc = 1'b0;
        tick();
      end
      mem_respcyc = 1'b1;
      mem_resp    = b0 + step * k;
      flush       = (k == flush_at);
      if (k == 0) check("respack", {63'd0, mem_respack}, 64'd1);
      tick();
    end
    mem_respcyc = 1'b0;
    flush       = 1'b0;
    check("fill_nodone", {63'd0, ic_done}, 64'd0);
    tick();
    check("miss_done", {63'd0, ic_done}, 64'd1);
    check("miss_w0", idata[63:0], b0);
    check("miss_w7", idata[511:448], b0 + step * 7);
    tick();
    check("done_pulse", {63'd0, ic_done}, 64'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    ic_enable   = 1'b0;
    iaddr       = '0;
    flush       = 1'b0;
    mem_reqack  = 1'b0;
    mem_respcyc = 1'b0;
    mem_resp    = '0;
    tick();
    tick();
    check("rst_done", {63'd0, ic_done}, 64'd0);
    check("rst_reqcyc", {63'd0, mem_reqcyc}, 64'd0);
    check("rst_idata", {63'd0, |idata}, 64'd0);
    check("rst_memreq", mem_req, 64'd0);
    reset_n = 1'b1;
    tick();

    request(64'h1000, 1'b0);
    check("cold_reqcyc", {63'd0, mem_reqcyc}, 64'd1);
    check("cold_memreq", mem_req, 64'h1000);
    tick();
    tick();
    check("reqcyc_hold", {63'd0, mem_reqcyc}, 64'd1);
    check("memreq_hold", mem_req, 64'h1000);
    refill(64'h11, 64'h11, 3, -1);
    check("cold_w1", idata[127:64], 64'h22);

    request(64'h1023, 1'b0);
    check("hit_done", {63'd0, ic_done}, 64'd1);
    check("hit_reqcyc", {63'd0, mem_reqcyc}, 64'd0);
    check("hit_w0", idata[63:0], 64'h11);
    check("hit_w7", idata[511:448], 64'h88);
    tick();
    check("hit_pulse", {63'd0, ic_done}, 64'd0);

    request(64'h2000, 1'b0);
    check("conf_reqcyc", {63'd0, mem_reqcyc}, 64'd1);
    check("conf_memreq", mem_req, 64'h2000);
    refill(64'hA00, 64'h1, -1, -1);
    request(64'h1000, 1'b0);
    check("evict_miss", {63'd0, mem_reqcyc}, 64'd1);
    check("evict_done", {63'd0, ic_done}, 64'd0);
    refill(64'h11, 64'h11, -1, -1);
`ifdef ICACHE_STATS_EN
    check("stat_hit", {32'd0, hit_count}, 64'd1);
    check("stat_miss", {32'd0, miss_count}, 64'd3);
`endif

    request(64'h1008, 1'b0);
    check("rehit_done", {63'd0, ic_done}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    request(64'h1000, 1'b0);
    check("flush_miss", {63'd0, mem_reqcyc}, 64'd1);
    refill(64'h500, 64'h1, -1, 2);
    request(64'h1000, 1'b0);
    check("fresp_miss", {63'd0, mem_reqcyc}, 64'd1);
    refill(64'h11, 64'h11, -1, -1);
    request(64'h1000, 1'b1);
    check("flush_en_miss", {63'd0, mem_reqcyc}, 64'd1);
    check("flush_en_done", {63'd0, ic_done}, 64'd0);
    refill(64'h11, 64'h11, 5, -1);

    request(64'h3000, 1'b0);
    check("r6_memreq", mem_req, 64'h3000);
    mem_reqack = 1'b1;
    tick();
    mem_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_respcyc = 1'b1;
      mem_resp    = 64'h70 + k;
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("r6_reqcyc", {63'd0, mem_reqcyc}, 64'd0);
    check("r6_idata", {63'd0, |idata}, 64'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 4; k < 8; k++) begin
      mem_resp = 64'h70 + k;
      tick();
      check("r6_nodone", {63'd0, ic_done}, 64'd0);
    end
    mem_respcyc = 1'b0;
    tick();
    check("r6_idle_done", {63'd0, ic_done}, 64'd0);
    check("r6_idle_req", {63'd0, mem_reqcyc}, 64'd0);
`ifdef ICACHE_STATS_EN
    check("r6_stat_miss", {32'd0, miss_count}, 64'd0);
`endif
    request(64'h1000, 1'b0);
    check("r6_cold_miss", {63'd0, mem_reqcyc}, 64'd1);
    refill(64'h900, 64'h10, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
